nes_cpu_bus_responder: RTL



---
 rtl/nes_cpu_bus_responder_pkg.sv | 46 ++++
 rtl/nes_cpu_bus_responder_if.sv | 40 ++++
 rtl/nes_cpu_bus_responder_oam_dma.sv | 61 ++++++
 rtl/nes_cpu_bus_responder.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/nes_cpu_bus_responder_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | nes_cpu_bus_responder_pkg                                                  |
// | Shared CPU memory-map constants, DMA state and read-source encodings.      |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
package nes_cpu_bus_responder_pkg;

    localparam logic [15:0] c_ram_mask      = 16'hE000;
    localparam logic [15:0] c_ram_base      = 16'h0000;
    localparam logic [15:0] c_ppu_mask      = 16'hE000;
    localparam logic [15:0] c_ppu_base      = 16'h2000;
    localparam logic [15:0] c_prg_mask      = 16'h8000;
    localparam logic [15:0] c_prg_base      = 16'h8000;

    localparam logic [2:0]  c_ppu_oamdata   = 3'd4;
    localparam logic [7:0]  c_pad_open_bits = 8'h40;

    // DMA source pages: below c_dma_ram_top is RAM, from c_dma_prg_page up is PRG
    localparam logic [7:0]  c_dma_ram_top   = 8'h20;
    localparam logic [7:0]  c_dma_prg_page  = 8'h80;

    typedef enum logic [1:0] {
        DMA_IDLE  = 2'd0,
        DMA_ALIGN = 2'd1,
        DMA_RD    = 2'd2,
        DMA_WR    = 2'd3
    } dma_state_t;

    typedef enum logic [2:0] {
        SRC_NONE = 3'd0,
        SRC_RAM  = 3'd1,
        SRC_PPU  = 3'd2,
        SRC_PRG  = 3'd3,
        SRC_PAD  = 3'd4,
        SRC_OPEN = 3'd5
    } src_sel_t;

    function automatic logic in_window(input logic [15:0] addr,
                                       input logic [15:0] mask,
                                       input logic [15:0] base);
        return (addr & mask) == base;
    endfunction

endpackage
`default_nettype wire

// File: rtl/nes_cpu_bus_responder_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | nes_cpu_bus_responder_if                                                   |
// | CPU bus, PPU register port, PRG ROM port and controller inputs.            |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
interface nes_cpu_bus_responder_if;

    logic [15:0] cpu_addr;
    logic        cpu_rw_n;
    logic [7:0]  cpu_data_in;
    logic [7:0]  cpu_data_out;
    logic        cpu_data_oe;
    logic        cpu_halt;
    logic [2:0]  ppu_addr;
    logic [7:0]  ppu_wdata;
    logic        ppu_we;
    logic        ppu_re;
    logic [7:0]  ppu_rdata;
    logic [14:0] prg_addr;
    logic [7:0]  prg_rdata;
    logic [7:0]  pad1_btn;
    logic [7:0]  pad2_btn;

    modport master (
        output cpu_addr, cpu_rw_n, cpu_data_in, ppu_rdata, prg_rdata,
               pad1_btn, pad2_btn,
        input  cpu_data_out, cpu_data_oe, cpu_halt, ppu_addr, ppu_wdata,
               ppu_we, ppu_re, prg_addr
    );

    modport slave (
        input  cpu_addr, cpu_rw_n, cpu_data_in, ppu_rdata, prg_rdata,
               pad1_btn, pad2_btn,
        output cpu_data_out, cpu_data_oe, cpu_halt, ppu_addr, ppu_wdata,
               ppu_we, ppu_re, prg_addr
    );

endinterface
`default_nettype wire

// File: rtl/nes_cpu_bus_responder_oam_dma.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | nes_oam_dma                                                                |
// | OAM DMA sequencer: page/index registers, read/write phases, CPU halt.      |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module nes_oam_dma
    import nes_cpu_bus_responder_pkg::*;
(
    input  wire logic        clk,
    input  wire logic        rst_n,
    input  wire logic        trigger,
    input  wire logic [7:0]  page_in,
    output logic             halt,
    output logic             rd,
    output logic             wr,
    output logic [14:0]      src_addr,
    output logic [7:0]       page
);

    dma_state_t r_state;
    dma_state_t w_state_next;
    logic [7:0] r_page;
    logic [7:0] r_idx;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= DMA_IDLE;
            r_page  <= 8'd0;
            r_idx   <= 8'd0;
        end else begin
            r_state <= w_state_next;
            if (r_state == DMA_IDLE && trigger) begin
                r_page <= page_in;
                r_idx  <= 8'd0;
            end else if (r_state == DMA_WR) begin
                r_idx  <= r_idx + 8'd1;
            end
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            DMA_IDLE:  if (trigger) w_state_next = DMA_ALIGN;
            DMA_ALIGN: w_state_next = DMA_RD;
            DMA_RD:    w_state_next = DMA_WR;
            DMA_WR:    w_state_next = (r_idx == 8'hFF) ? DMA_IDLE : DMA_RD;
            default:   w_state_next = DMA_IDLE;
        endcase
    end

    // Outputs decode the state alone so the top's halt-gated trigger forms no loop
    assign halt     = (r_state != DMA_IDLE);
    assign rd       = (r_state == DMA_RD);
    assign wr       = (r_state == DMA_WR);
    assign src_addr = {r_page[6:0], r_idx};
    assign page     = r_page;

endmodule
`default_nettype wire

// File: rtl/nes_cpu_bus_responder.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | nes_cpu_bus_responder                                                      |
// | CPU bus target: RAM, PPU window, controller ports, PRG window, OAM DMA.    |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module nes_cpu_bus_responder
    import nes_cpu_bus_responder_pkg::*;
#(
    parameter int unsigned  RAM_AW  = 11,
    parameter logic [15:0]  DMA_REG = 16'h4014,
    parameter logic [15:0]  PAD_REG = 16'h4016
) (
    input  wire logic               clk,
    input  wire logic               rst_n,
    nes_cpu_bus_responder_if.slave  bus
);

    logic              w_halt;
    logic              w_dma_rd;
    logic              w_dma_wr;
    logic [14:0]       w_dma_src;
    logic [7:0]        w_dma_page;
    logic [7:0]        w_dma_byte;

    logic              w_rd;
    logic              w_wr;
    logic              w_is_ram;
    logic              w_is_ppu;
    logic              w_is_prg;
    logic              w_is_pad1;
    logic              w_is_pad2;
    logic              w_is_dma;
    src_sel_t          w_src;
    src_sel_t          r_sel;
    logic              r_rd_valid;
    logic [7:0]        w_data_out;
    logic [7:0]        r_open_bus;

    logic [7:0]        r_mem [0:(1 << RAM_AW) - 1];
    logic [RAM_AW-1:0] w_ram_raddr;
    logic [7:0]        r_ram_q;

    logic              r_strobe;
    logic [7:0]        r_sr1;
    logic [7:0]        r_sr2;
    logic              w_pad_bit;
    logic [7:0]        r_pad_q;

    logic              r_ppu_we;
    logic [2:0]        r_ppu_waddr;
    logic [7:0]        r_ppu_wdata;

    // The CPU bus is ignored entirely while DMA holds the CPU
    assign w_rd = !w_halt &&  bus.cpu_rw_n;
    assign w_wr = !w_halt && !bus.cpu_rw_n;

    assign w_is_ram  = in_window(bus.cpu_addr, c_ram_mask, c_ram_base);
    assign w_is_ppu  = in_window(bus.cpu_addr, c_ppu_mask, c_ppu_base);
    assign w_is_prg  = in_window(bus.cpu_addr, c_prg_mask, c_prg_base);
    assign w_is_pad1 = (bus.cpu_addr == PAD_REG);
    assign w_is_pad2 = (bus.cpu_addr == PAD_REG + 16'd1);
    assign w_is_dma  = (bus.cpu_addr == DMA_REG);

    always_comb begin
        w_src = SRC_OPEN;
        if (w_is_ram)                    w_src = SRC_RAM;
        else if (w_is_ppu)               w_src = SRC_PPU;
        else if (w_is_prg)               w_src = SRC_PRG;
        else if (w_is_pad1 || w_is_pad2) w_src = SRC_PAD;
    end

    nes_oam_dma u_dma (
        .clk      (clk),
        .rst_n    (rst_n),
        .trigger  (w_wr && w_is_dma),
        .page_in  (bus.cpu_data_in),
        .halt     (w_halt),
        .rd       (w_dma_rd),
        .wr       (w_dma_wr),
        .src_addr (w_dma_src),
        .page     (w_dma_page)
    );

    assign w_ram_raddr = w_dma_rd ? w_dma_src[RAM_AW-1:0] : bus.cpu_addr[RAM_AW-1:0];

    always_ff @(posedge clk) begin
        if (w_wr && w_is_ram) begin
            r_mem[bus.cpu_addr[RAM_AW-1:0]] <= bus.cpu_data_in;
        end
        r_ram_q <= r_mem[w_ram_raddr];
    end

    always_comb begin
        w_dma_byte = 8'h00;
        if (w_dma_page < c_dma_ram_top)        w_dma_byte = r_ram_q;
        else if (w_dma_page >= c_dma_prg_page) w_dma_byte = bus.prg_rdata;
    end

    // With strobe high the port reflects the live A button
    assign w_pad_bit = r_strobe ? (w_is_pad2 ? bus.pad2_btn[0] : bus.pad1_btn[0])
                                : (w_is_pad2 ? r_sr2[0]        : r_sr1[0]);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_sel       <= SRC_NONE;
            r_rd_valid  <= 1'b0;
            r_pad_q     <= 8'd0;
            r_open_bus  <= 8'd0;
            r_strobe    <= 1'b0;
            r_sr1       <= 8'd0;
            r_sr2       <= 8'd0;
            r_ppu_we    <= 1'b0;
            r_ppu_waddr <= 3'd0;
            r_ppu_wdata <= 8'd0;
        end else begin
            r_rd_valid <= w_rd;
            r_sel      <= w_rd ? w_src : SRC_NONE;
            r_pad_q    <= c_pad_open_bits | {7'd0, w_pad_bit};

            // A CPU write in the cycle a read completes owns the bus, so it wins
            if (w_wr) begin
                r_open_bus <= bus.cpu_data_in;
            end else if (r_rd_valid) begin
                r_open_bus <= w_data_out;
            end

            r_ppu_we <= w_wr && w_is_ppu;
            if (w_wr && w_is_ppu) begin
                r_ppu_waddr <= bus.cpu_addr[2:0];
                r_ppu_wdata <= bus.cpu_data_in;
            end

            if (w_wr && w_is_pad1) begin
                r_strobe <= bus.cpu_data_in[0];
            end
            if (r_strobe) begin
                r_sr1 <= bus.pad1_btn;
                r_sr2 <= bus.pad2_btn;
            end else begin
                if (w_rd && w_is_pad1) r_sr1 <= {1'b1, r_sr1[7:1]};
                if (w_rd && w_is_pad2) r_sr2 <= {1'b1, r_sr2[7:1]};
            end
        end
    end

    always_comb begin
        w_data_out = 8'd0;
        case (r_sel)
            SRC_RAM:  w_data_out = r_ram_q;
            SRC_PPU:  w_data_out = bus.ppu_rdata;
            SRC_PRG:  w_data_out = bus.prg_rdata;
            SRC_PAD:  w_data_out = r_pad_q;
            SRC_OPEN: w_data_out = r_open_bus;
            default:  w_data_out = 8'd0;
        endcase
    end

    assign bus.cpu_data_out = w_data_out;
    assign bus.cpu_data_oe  = r_rd_valid && bus.cpu_rw_n && !w_halt;
    assign bus.cpu_halt     = w_halt;

    assign bus.ppu_re = w_rd && w_is_ppu;

    // A pending CPU write outranks a same-cycle PPU read address
    always_comb begin
        bus.ppu_we    = 1'b0;
        bus.ppu_addr  = 3'd0;
        bus.ppu_wdata = r_ppu_wdata;
        if (w_dma_wr) begin
            bus.ppu_we    = 1'b1;
            bus.ppu_addr  = c_ppu_oamdata;
            bus.ppu_wdata = w_dma_byte;
        end else if (r_ppu_we) begin
            bus.ppu_we    = 1'b1;
            bus.ppu_addr  = r_ppu_waddr;
        end else if (bus.ppu_re) begin
            bus.ppu_addr  = bus.cpu_addr[2:0];
        end
    end

    always_comb begin
        bus.prg_addr = 15'd0;
        if (w_dma_rd)              bus.prg_addr = w_dma_src;
        else if (w_rd && w_is_prg) bus.prg_addr = bus.cpu_addr[14:0];
    end

endmodule
`default_nettype wire
